// File: rtl/piso_shift_register_pkg.sv
// rtl/piso_shift_register_pkg.sv - shared state encoding and counter sizing for the PISO transmitter
package piso_shift_register_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits needed to hold width-1; never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_register_down_counter.sv
// rtl/piso_shift_register_down_counter.sv - loadable down counter that saturates at zero
module piso_shift_register_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - parallel-in serial-out transmitter with valid/ready load and serial handshakes
module piso_shift_register
    import piso_shift_register_pkg::*;
#(
    parameter int n         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] I,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         done
);

    localparam int CW = cnt_width(n);

    state_t       state;
    state_t       state_next;
    logic [n-1:0] shreg;
    logic [n-1:0] shifted;
    logic         cnt_zero;
    logic         load_acc;
    logic         bit_acc;
    logic         done_d;

    assign load_ready = (state == IDLE) || (cnt_zero && ser_ready);
    assign load_acc   = load_valid && load_ready;
    assign bit_acc    = (state == SHIFT) && ser_ready;

    // Vacated position fills with zero so the line idles low once a word drains.
    assign shifted = MSB_FIRST ? {shreg[n-2:0], 1'b0} : {1'b0, shreg[n-1:1]};

    piso_shift_register_down_counter #(
        .W(CW)
    ) u_bit_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (load_acc),
        .load_value(CW'(n - 1)),
        .enable    (bit_acc),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_next = state;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                if (load_acc) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_acc && cnt_zero) begin
                    done_d = 1'b1;
                    if (!load_acc) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_d;
            if (load_acc) begin
                shreg <= I;
            end else if (bit_acc) begin
                shreg <= shifted;
            end
        end
    end

    assign ser_out   = MSB_FIRST ? shreg[n-1] : shreg[0];
    assign ser_valid = (state == SHIFT);

endmodule

// File: tb/tb_piso_shift_register.sv
// tb/tb_piso_shift_register.sv - directed self-checking bench for piso_shift_register
module tb_piso_shift_register;

    logic       clk;
    logic       reset;
    logic [3:0] m_i;
    logic       m_load_valid;
    logic       m_load_ready;
    logic       m_ser_out;
    logic       m_ser_valid;
    logic       m_ser_ready;
    logic       m_done;
    logic [3:0] l_i;
    logic       l_load_valid;
    logic       l_load_ready;
    logic       l_ser_out;
    logic       l_ser_valid;
    logic       l_ser_ready;
    logic       l_done;

    int tests_run;
    int tests_failed;

    piso_shift_register #(.n(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .I         (m_i),
        .load_valid(m_load_valid),
        .load_ready(m_load_ready),
        .ser_out   (m_ser_out),
        .ser_valid (m_ser_valid),
        .ser_ready (m_ser_ready),
        .done      (m_done)
    );

    piso_shift_register #(.n(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .I         (l_i),
        .load_valid(l_load_valid),
        .load_ready(l_load_ready),
        .ser_out   (l_ser_out),
        .ser_valid (l_ser_valid),
        .ser_ready (l_ser_ready),
        .done      (l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check one cycle of the selected instance, then advance past the next rising edge.
    task automatic cyc(input string tag, input bit lsb, input logic e_sv, input logic e_so,
                       input logic e_done, input logic e_lr);
        #1;
        if (lsb) begin
            chk({tag, ".ser_valid"},  l_ser_valid,  e_sv);
            chk({tag, ".ser_out"},    l_ser_out,    e_so);
            chk({tag, ".done"},       l_done,       e_done);
            chk({tag, ".load_ready"}, l_load_ready, e_lr);
        end else begin
            chk({tag, ".ser_valid"},  m_ser_valid,  e_sv);
            chk({tag, ".ser_out"},    m_ser_out,    e_so);
            chk({tag, ".done"},       m_done,       e_done);
            chk({tag, ".load_ready"}, m_load_ready, e_lr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        l_i          = 4'b0000;
        l_load_valid = 1'b0;
        l_ser_ready  = 1'b1;

        // 1: reset with random inputs
        reset        = 1'b1;
        m_i          = 4'($urandom);
        m_load_valid = 1'($urandom);
        m_ser_ready  = 1'($urandom);
        @(posedge clk);
        #1;
        m_i          = 4'($urandom);
        m_load_valid = 1'($urandom);
        m_ser_ready  = 1'($urandom);
        cyc("rst1", 0, 0, 0, 0, 1);
        reset        = 1'b0;
        m_load_valid = 1'b0;
        m_ser_ready  = 1'b1;
        chk("rst1.lsb_valid", l_ser_valid, 1'b0);
        chk("rst1.lsb_done",  l_done,      1'b0);
        cyc("rst2", 0, 0, 0, 0, 1);

        // 2: basic MSB-first transfer of 1011
        m_i = 4'b1011; m_load_valid = 1'b1;
        cyc("s2_load", 0, 0, 0, 0, 1);
        m_load_valid = 1'b0;
        cyc("s2_b1", 0, 1, 1, 0, 0);
        cyc("s2_b2", 0, 1, 0, 0, 0);
        cyc("s2_b3", 0, 1, 1, 0, 0);
        cyc("s2_b4", 0, 1, 1, 0, 1);
        cyc("s2_done", 0, 0, 0, 1, 1);
        cyc("s2_idle", 0, 0, 0, 0, 1);

        // 3: backpressure on the 2nd and 3rd bit cycles
        m_i = 4'b1011; m_load_valid = 1'b1;
        cyc("s3_load", 0, 0, 0, 0, 1);
        m_load_valid = 1'b0;
        cyc("s3_b1", 0, 1, 1, 0, 0);
        m_ser_ready = 1'b0;
        cyc("s3_hold1", 0, 1, 0, 0, 0);
        cyc("s3_hold2", 0, 1, 0, 0, 0);
        m_ser_ready = 1'b1;
        cyc("s3_b2", 0, 1, 0, 0, 0);
        cyc("s3_b3", 0, 1, 1, 0, 0);
        cyc("s3_b4", 0, 1, 1, 0, 1);
        cyc("s3_done", 0, 0, 0, 1, 1);
        cyc("s3_idle", 0, 0, 0, 0, 1);

        // 4: back-to-back words 1011 then 0110
        m_i = 4'b1011; m_load_valid = 1'b1;
        cyc("s4_load", 0, 0, 0, 0, 1);
        m_load_valid = 1'b0;
        cyc("s4_b1", 0, 1, 1, 0, 0);
        cyc("s4_b2", 0, 1, 0, 0, 0);
        cyc("s4_b3", 0, 1, 1, 0, 0);
        m_i = 4'b0110; m_load_valid = 1'b1;
        cyc("s4_b4", 0, 1, 1, 0, 1);
        m_load_valid = 1'b0;
        cyc("s4_b5", 0, 1, 0, 1, 0);
        cyc("s4_b6", 0, 1, 1, 0, 0);
        cyc("s4_b7", 0, 1, 1, 0, 0);
        cyc("s4_b8", 0, 1, 0, 0, 1);
        cyc("s4_done", 0, 0, 0, 1, 1);
        cyc("s4_idle", 0, 0, 0, 0, 1);

        // 5: reset after two accepted bits, then a clean word 0001
        m_i = 4'b1011; m_load_valid = 1'b1;
        cyc("s5_load", 0, 0, 0, 0, 1);
        m_load_valid = 1'b0;
        cyc("s5_b1", 0, 1, 1, 0, 0);
        cyc("s5_b2", 0, 1, 0, 0, 0);
        reset = 1'b1;
        cyc("s5_rst", 0, 1, 1, 0, 0);
        reset = 1'b0;
        cyc("s5_abort", 0, 0, 0, 0, 1);
        m_i = 4'b0001; m_load_valid = 1'b1;
        cyc("s5_nodone", 0, 0, 0, 0, 1);
        m_load_valid = 1'b0;
        cyc("s5_c1", 0, 1, 0, 0, 0);
        cyc("s5_c2", 0, 1, 0, 0, 0);
        cyc("s5_c3", 0, 1, 0, 0, 0);
        cyc("s5_c4", 0, 1, 1, 0, 1);
        cyc("s5_done", 0, 0, 0, 1, 1);

        // 6: LSB-first 1011, with a second word 0010 held on load_valid during SHIFT
        l_i = 4'b1011; l_load_valid = 1'b1;
        cyc("s6_load", 1, 0, 0, 0, 1);
        l_i = 4'b0010;
        cyc("s6_b1", 1, 1, 1, 0, 0);
        cyc("s6_b2", 1, 1, 1, 0, 0);
        cyc("s6_b3", 1, 1, 0, 0, 0);
        cyc("s6_b4", 1, 1, 1, 0, 1);
        l_load_valid = 1'b0;
        cyc("s6_c1", 1, 1, 0, 1, 0);
        cyc("s6_c2", 1, 1, 1, 0, 0);
        cyc("s6_c3", 1, 1, 0, 0, 0);
        cyc("s6_c4", 1, 1, 0, 0, 1);
        cyc("s6_done", 1, 0, 0, 1, 1);
        cyc("s6_idle", 1, 0, 0, 0, 1);
        chk("s6_msb_quiet", m_ser_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
Parallel-in, serial-out transmitter and the serialising counterpart of the team's parallel capture register. It accepts an n-bit word through a valid/ready load handshake and shifts it out one bit per accepted cycle on a valid/ready serial interface. It sits between word-wide datapath registers and single-wire serial links.

Parameters:
n, 4, word width in bits; legal range n >= 2.
MSB_FIRST, 1, 1 = transmit I[n-1] first; 0 = transmit I[0] first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
I  input  n  parallel word to transmit.
load_valid  input  1  I holds a word to transmit.
load_ready  output  1  block can accept a word this cycle.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out holds a valid bit.
ser_ready  input  1  sink accepts ser_out this cycle.
done  output  1  one-cycle pulse after the last bit of a word is accepted.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled on the rising edge of clk, and it overrides every other input.
- Reset values:
  - state = IDLE, shift register = 0, bit counter = 0.
  - ser_out = 0, ser_valid = 0, done = 0, load_ready = 1.
- Two states:
  - IDLE: load_ready = 1, ser_valid = 0.
  - SHIFT: ser_valid = 1.
- Load accept: an edge where load_valid && load_ready.
  - shift register <= I, counter <= n-1, state <= SHIFT.
  - The first bit is visible on ser_out with ser_valid = 1 in the next cycle (latency 1).
- SHIFT, bit accept (edge with ser_ready = 1):
  - counter != 0: shift toward the output end (left if MSB_FIRST, else right), fill the vacated bit with 0, counter decrements.
  - counter == 0: last bit consumed. done <= 1 for exactly the next cycle. State <= IDLE unless a new load is accepted on the same edge.
- SHIFT with ser_ready = 0: shift register, counter, ser_out and ser_valid all hold. The sink sees stable data.
- Output timing:
  - ser_out, ser_valid and done are driven directly from registers (no combinational path from inputs).
  - load_ready is combinational: 1 in IDLE; 1 in SHIFT only when counter == 0 && ser_ready; otherwise 0.
- Back-to-back: a load accepted on the same edge as the last-bit accept loads the new word, and state stays in SHIFT.
  - ser_valid stays high with no bubble.
  - done still pulses for the finished word.
- load_valid while load_ready = 0: ignored; the word is not captured and its source must hold it.
- Reset mid-word: the transfer is aborted and no done pulse is produced. ser_valid is 0 in the cycle after the reset edge.
- Counter width: $clog2(n). The counter never wraps below 0.

Decomposition:
- Shared package:
  - state encoding: IDLE = 1'b0, SHIFT = 1'b1.
  - a counter-width function for clog2(n).
- One sub-module is natural: down_counter.
  - Ports: load, load value, enable, zero flag.
  - Width parameter equal to the counter width.
  - The FSM and shift register remain in piso_shift_register.

Test Plan:
1. Reset: assert reset for 2 cycles with random inputs -> ser_valid = 0, ser_out = 0, done = 0, load_ready = 1 on every cycle after the first reset edge.
2. Basic transfer (n = 4, MSB_FIRST = 1, ser_ready held 1): load I = 4'b1011 -> ser_out = 1, 0, 1, 1 on the 4 cycles after the load; done = 1 on the 5th cycle only; load_ready = 1 from the 4th cycle.
3. Backpressure: load 4'b1011, drop ser_ready during the 2nd and 3rd bit cycles -> ser_out holds 0 for 3 cycles; sequence and done otherwise identical to scenario 2, shifted by 2 cycles.
4. Back-to-back: load 4'b1011, then present 4'b0110 with load_valid during the last-bit cycle -> 8 contiguous ser_valid cycles carrying 1,0,1,1,0,1,1,0; done pulses after bit 4 and after bit 8.
5. Abort: load 4'b1011, assert reset after 2 bits are accepted -> ser_valid = 0 next cycle, no done pulse, load_ready = 1; a following load of 4'b0001 transmits 0,0,0,1 cleanly.
6. LSB-first (MSB_FIRST = 0): load 4'b1011 -> ser_out = 1, 1, 0, 1. A load_valid held during SHIFT is not captured until load_ready = 1.
